// File: rtl/risc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : risc_pkg                                                     |
// | Description : Shared widths, field bounds and fetch-FSM state encoding     |
// |               for the multi-cycle RISC front end.                          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package risc_pkg;

  localparam int INSTR_W    = 32;
  localparam int ADDR_W     = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 25;

  // Fetch FSM states, explicit 2-bit encoding.
  typedef enum logic [1:0] {
    IF_IDLE    = 2'd0,
    IF_REQ     = 2'd1,
    IF_HOLD    = 2'd2,
    IF_DISCARD = 2'd3
  } if_state_t;

  // Sequential PC advance; modulo 2^ADDR_W, overflow silently wraps.
  function automatic logic [ADDR_W-1:0] pc_advance(
    input logic [ADDR_W-1:0] pc,
    input logic [ADDR_W-1:0] step
  );
    return pc + step;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instruction_fetch                                            |
// | Description : Owns the program counter, issues one word read at a time to  |
// |               instruction memory (req/ack) and hands each fetched word,    |
// |               with its PC, to the decoder through a single-entry           |
// |               valid/ready register. Redirects flush the fetch path; a     |
// |               request in flight is never withdrawn, its data is dropped.   |
// | Ports       : clk, rst (async, active-high)                                |
// |               en                        fetch enable                       |
// |               imem_req/addr/ack/rdata   instruction memory handshake       |
// |               instr/instr_pc/valid/ready decoder interface                 |
// |               redirect/redirect_pc      downstream PC override             |
// |               pc                        current fetch PC                   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module instruction_fetch
  import risc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] PC_STEP  = 32'h0000_0001
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  pc
);

  if_state_t          r_state,    w_state_nxt;
  logic [ADDR_W-1:0]  r_pc,       w_pc_nxt;
  logic               r_req,      w_req_nxt;
  logic [ADDR_W-1:0]  r_addr,     w_addr_nxt;
  logic [INSTR_W-1:0] r_instr,    w_instr_nxt;
  logic [ADDR_W-1:0]  r_instr_pc, w_instr_pc_nxt;
  logic               r_valid,    w_valid_nxt;

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IF_IDLE;
      r_pc       <= RESET_PC;
      r_req      <= 1'b0;
      r_addr     <= '0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_req      <= w_req_nxt;
      r_addr     <= w_addr_nxt;
      r_instr    <= w_instr_nxt;
      r_instr_pc <= w_instr_pc_nxt;
      r_valid    <= w_valid_nxt;
    end
  end

  // Next-state and next-output logic. Redirect overrides everything else in
  // every state, but an issued request (imem_req/imem_addr) stays up until
  // the memory acknowledges it.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_req_nxt      = r_req;
    w_addr_nxt     = r_addr;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;
    w_valid_nxt    = r_valid;

    case (r_state)
      IF_IDLE: begin
        if (redirect) begin
          w_pc_nxt = redirect_pc;
        end else if (en) begin
          w_req_nxt   = 1'b1;
          w_addr_nxt  = r_pc;
          w_state_nxt = IF_REQ;
        end
      end

      IF_REQ: begin
        if (redirect) begin
          w_pc_nxt    = redirect_pc;
          w_valid_nxt = 1'b0;
          if (imem_ack) begin
            // Returning word belongs to the old path: drop it.
            w_req_nxt   = 1'b0;
            w_state_nxt = IF_IDLE;
          end else begin
            w_state_nxt = IF_DISCARD;
          end
        end else if (imem_ack) begin
          w_instr_nxt    = imem_rdata;
          w_instr_pc_nxt = r_pc;
          w_valid_nxt    = 1'b1;
          w_pc_nxt       = pc_advance(r_pc, PC_STEP);
          w_req_nxt      = 1'b0;
          w_state_nxt    = IF_HOLD;
        end
      end

      IF_HOLD: begin
        if (redirect) begin
          // Cancels any same-cycle decoder handshake.
          w_pc_nxt    = redirect_pc;
          w_valid_nxt = 1'b0;
          w_state_nxt = IF_IDLE;
        end else if (instr_ready) begin
          w_valid_nxt = 1'b0;
          if (en) begin
            w_req_nxt   = 1'b1;
            w_addr_nxt  = r_pc;
            w_state_nxt = IF_REQ;
          end else begin
            w_state_nxt = IF_IDLE;
          end
        end
      end

      IF_DISCARD: begin
        if (redirect) begin
          w_pc_nxt = redirect_pc;
        end
        if (imem_ack) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = IF_IDLE;
        end
      end

      default: begin
        w_state_nxt = IF_IDLE;
        w_req_nxt   = 1'b0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_valid;
  assign pc          = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_instruction_fetch                                         |
// | Description : Directed, table-driven bench for instruction_fetch, plus     |
// |               hand-written reset and PC-wrap sequences.                    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_instruction_fetch;
  import risc_pkg::*;

  typedef struct {
    logic        en;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
    logic [31:0] e_pc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // DUT A: default reset PC
  logic        en = 1'b0, imem_ack = 1'b0, instr_ready = 1'b0, redirect = 1'b0;
  logic [31:0] imem_rdata = '0, redirect_pc = '0;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr, instr_pc, pc;

  // DUT B: reset PC at the top of the address space
  logic        b_en = 1'b0, b_ack = 1'b0, b_ready = 1'b0, b_redirect = 1'b0;
  logic [31:0] b_rdata = '0, b_redirect_pc = '0;
  logic        b_req, b_valid;
  logic [31:0] b_addr, b_instr, b_instr_pc, b_pc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instruction_fetch u_dut (
    .clk(clk), .rst(rst), .en(en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .pc(pc)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFF), .PC_STEP(32'h1)) u_dut_wrap (
    .clk(clk), .rst(rst), .en(b_en),
    .imem_req(b_req), .imem_addr(b_addr), .imem_ack(b_ack), .imem_rdata(b_rdata),
    .instr(b_instr), .instr_pc(b_instr_pc), .instr_valid(b_valid), .instr_ready(b_ready),
    .redirect(b_redirect), .redirect_pc(b_redirect_pc), .pc(b_pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(
    input logic en_i, input logic ack_i, input logic [31:0] rdata_i, input logic ready_i,
    input logic redir_i, input logic [31:0] rpc_i,
    input logic req_e, input logic [31:0] addr_e, input logic valid_e,
    input logic [31:0] instr_e, input logic [31:0] ipc_e, input logic [31:0] pc_e);
    vec_t v;
    v.en = en_i; v.ack = ack_i; v.rdata = rdata_i; v.ready = ready_i;
    v.redir = redir_i; v.rpc = rpc_i;
    v.e_req = req_e; v.e_addr = addr_e; v.e_valid = valid_e;
    v.e_instr = instr_e; v.e_ipc = ipc_e; v.e_pc = pc_e;
    return v;
  endfunction

  vec_t vq[$];

  initial begin
    // en ack rdata ready redir rpc | req addr valid instr ipc pc
    // Streaming fetch, 1-cycle ack
    vq.push_back(mk(1,0,32'h0,1,0,0,           1,32'h0, 0,32'h0,        32'h0, 32'h0));
    vq.push_back(mk(1,1,32'h0A00_0001,1,0,0,   0,32'h0, 1,32'h0A00_0001,32'h0, 32'h1));
    vq.push_back(mk(1,0,32'h0,1,0,0,           1,32'h1, 0,32'h0A00_0001,32'h0, 32'h1));
    vq.push_back(mk(1,1,32'h0A00_0002,1,0,0,   0,32'h1, 1,32'h0A00_0002,32'h1, 32'h2));
    vq.push_back(mk(1,0,32'h0,1,0,0,           1,32'h2, 0,32'h0A00_0002,32'h1, 32'h2));
    vq.push_back(mk(1,1,32'h0A00_0003,1,0,0,   0,32'h2, 1,32'h0A00_0003,32'h2, 32'h3));
    vq.push_back(mk(1,0,32'h0,1,0,0,           1,32'h3, 0,32'h0A00_0003,32'h2, 32'h3));
    vq.push_back(mk(1,1,32'h0A00_0004,1,0,0,   0,32'h3, 1,32'h0A00_0004,32'h3, 32'h4));
    // Backpressure: hold 1234_5678 for 5 cycles, accept on the 6th
    vq.push_back(mk(1,0,32'h0,1,0,0,           1,32'h4, 0,32'h0A00_0004,32'h3, 32'h4));
    vq.push_back(mk(1,1,32'h1234_5678,0,0,0,   0,32'h4, 1,32'h1234_5678,32'h4, 32'h5));
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(1,0,32'h0,0,0,0,         0,32'h4, 1,32'h1234_5678,32'h4, 32'h5));
    vq.push_back(mk(1,0,32'h0,1,0,0,           1,32'h5, 0,32'h1234_5678,32'h4, 32'h5));
    // Redirect in REQ, ack 3 cycles later; second redirect while discarding
    vq.push_back(mk(1,0,32'h0,1,1,32'h40,      1,32'h5, 0,32'h1234_5678,32'h4, 32'h40));
    vq.push_back(mk(1,0,32'h0,1,1,32'h48,      1,32'h5, 0,32'h1234_5678,32'h4, 32'h48));
    vq.push_back(mk(1,0,32'h0,1,0,0,           1,32'h5, 0,32'h1234_5678,32'h4, 32'h48));
    vq.push_back(mk(1,1,32'hDEAD_BEEF,1,0,0,   0,32'h5, 0,32'h1234_5678,32'h4, 32'h48));
    vq.push_back(mk(1,0,32'h0,1,0,0,           1,32'h48,0,32'h1234_5678,32'h4, 32'h48));
    // Redirect in the same cycle as ack
    vq.push_back(mk(1,1,32'h0A00_00AA,1,1,32'h80, 0,32'h48,0,32'h1234_5678,32'h4, 32'h80));
    vq.push_back(mk(1,0,32'h0,1,0,0,           1,32'h80,0,32'h1234_5678,32'h4, 32'h80));
    // Redirect in HOLD with instr_ready=1
    vq.push_back(mk(1,1,32'h0B00_0001,0,0,0,   0,32'h80,1,32'h0B00_0001,32'h80,32'h81));
    vq.push_back(mk(1,0,32'h0,1,1,32'h100,     0,32'h80,0,32'h0B00_0001,32'h80,32'h100));
    vq.push_back(mk(0,0,32'h0,1,0,0,           0,32'h80,0,32'h0B00_0001,32'h80,32'h100));
    vq.push_back(mk(1,0,32'h0,1,0,0,           1,32'h100,0,32'h0B00_0001,32'h80,32'h100));
    // en dropped mid-request: request completes, no follow-up
    vq.push_back(mk(0,0,32'h0,0,0,0,           1,32'h100,0,32'h0B00_0001,32'h80,32'h100));
    vq.push_back(mk(0,1,32'h0C00_0001,0,0,0,   0,32'h100,1,32'h0C00_0001,32'h100,32'h101));
    vq.push_back(mk(0,0,32'h0,1,0,0,           0,32'h100,0,32'h0C00_0001,32'h100,32'h101));
    vq.push_back(mk(0,0,32'h0,1,0,0,           0,32'h100,0,32'h0C00_0001,32'h100,32'h101));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   {31'b0, imem_req},    32'h0);
    chk("rst_addr",  imem_addr,            32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_instr", instr,                32'h0);
    chk("rst_ipc",   instr_pc,             32'h0);
    chk("rst_pc",    pc,                   32'h0);
    chk("rst_pc_b",  b_pc,                 32'hFFFF_FFFF);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven run
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      en = vq[i].en; imem_ack = vq[i].ack; imem_rdata = vq[i].rdata;
      instr_ready = vq[i].ready; redirect = vq[i].redir; redirect_pc = vq[i].rpc;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_req", i),   {31'b0, imem_req},    {31'b0, vq[i].e_req});
      chk($sformatf("v%0d_addr", i),  imem_addr,            vq[i].e_addr);
      chk($sformatf("v%0d_valid", i), {31'b0, instr_valid}, {31'b0, vq[i].e_valid});
      chk($sformatf("v%0d_instr", i), instr,                vq[i].e_instr);
      chk($sformatf("v%0d_ipc", i),   instr_pc,             vq[i].e_ipc);
      chk($sformatf("v%0d_pc", i),    pc,                   vq[i].e_pc);
    end

    // Reset while a request is outstanding; late ack must be ignored
    @(negedge clk);
    en = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
    @(posedge clk); #1;
    chk("mr_req_up",   {31'b0, imem_req}, 32'h1);
    chk("mr_addr_up",  imem_addr,         32'h101);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mr_async_req",   {31'b0, imem_req},    32'h0);
    chk("mr_async_addr",  imem_addr,            32'h0);
    chk("mr_async_valid", {31'b0, instr_valid}, 32'h0);
    chk("mr_async_instr", instr,                32'h0);
    chk("mr_async_ipc",   instr_pc,             32'h0);
    chk("mr_async_pc",    pc,                   32'h0);
    @(negedge clk);
    rst = 1'b0; en = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hFFFF_0000;
    @(posedge clk); #1;
    chk("mr_late_req",   {31'b0, imem_req},    32'h0);
    chk("mr_late_valid", {31'b0, instr_valid}, 32'h0);
    chk("mr_late_instr", instr,                32'h0);
    chk("mr_late_pc",    pc,                   32'h0);
    @(negedge clk);
    en = 1'b1; imem_ack = 1'b0;
    @(posedge clk); #1;
    chk("mr_restart_req",  {31'b0, imem_req}, 32'h1);
    chk("mr_restart_addr", imem_addr,         32'h0);
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 32'h0A00_0001;
    @(posedge clk); #1;
    chk("mr_restart_instr", instr,    32'h0A00_0001);
    chk("mr_restart_ipc",   instr_pc, 32'h0);
    chk("mr_restart_op",    {25'b0, instr[OPCODE_MSB:OPCODE_LSB]}, 32'h5);

    // PC wrap on the second instance
    @(negedge clk);
    b_en = 1'b1;
    @(posedge clk); #1;
    chk("wrap_req",  {31'b0, b_req}, 32'h1);
    chk("wrap_addr", b_addr,         32'hFFFF_FFFF);
    @(negedge clk);
    b_ack = 1'b1; b_rdata = 32'h0D00_0001;
    @(posedge clk); #1;
    chk("wrap_valid", {31'b0, b_valid}, 32'h1);
    chk("wrap_ipc",   b_instr_pc,       32'hFFFF_FFFF);
    chk("wrap_pc",    b_pc,             32'h0);
    @(negedge clk);
    b_ack = 1'b0; b_ready = 1'b1;
    @(posedge clk); #1;
    chk("wrap_next_req",  {31'b0, b_req}, 32'h1);
    chk("wrap_next_addr", b_addr,         32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
